// File: rtl/restador_pkg.sv
// Shared types and helpers for the multi-cycle subtraction controller.
package restador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // Signed overflow of a - b, judged from the MSBs of the operands and result.
  function automatic logic calc_v(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb ^ b_msb) & (a_msb ^ d_msb);
  endfunction

endpackage

// File: rtl/restador_slice.sv
// Combinational N-bit subtract slice: {bout, s} = a - b - bin, computed N+1 bits wide.
module restador_slice #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] s,
  output logic         bout
);

  // The extra top bit ends up set exactly when the slice needs to borrow.
  assign {bout, s} = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bin};

endmodule

// File: rtl/restador_secuencial.sv
// Multi-precision subtractor: one N-bit slice reused for W/N cycles, LSB slice first,
// with the borrow chained between cycles; flags match a single-shot W-bit subtractor.
module restador_secuencial
  import restador_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         borrow_in,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] dif,
  output logic         flag_n,
  output logic         flag_z,
  output logic         flag_c,
  output logic         flag_v,
  output logic         busy
);

  localparam int K     = W / N;
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(K - 1);

  if ((N < 1) || ((W % N) != 0)) begin : g_bad_width
    $error("restador_secuencial: W (%0d) must be a positive multiple of N (%0d)", W, N);
  end

  state_t           state, state_nx;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_r, b_r, dif_acc, dif_next, dif_r;
  logic             borrow_reg, z_acc;
  flags_t           flags_r;

  logic [N-1:0]     s;
  logic             bout;
  logic             accept, last_slice;

  assign accept     = start_valid & start_ready;
  assign last_slice = (idx == LAST);

  restador_slice #(.N(N)) u_slice (
    .a    (a_r[idx*N +: N]),
    .b    (b_r[idx*N +: N]),
    .bin  (borrow_reg),
    .s    (s),
    .bout (bout)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of the order of statements or processes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last_slice) state_nx = DONE;
      DONE:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Partial difference with the current slice merged in; only published on the last slice.
  always_comb begin
    dif_next = dif_acc;
    dif_next[idx*N +: N] = s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      a_r        <= '0;
      b_r        <= '0;
      borrow_reg <= 1'b0;
      z_acc      <= 1'b0;
      dif_acc    <= '0;
      dif_r      <= '0;
      flags_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r        <= a;
            b_r        <= b;
            borrow_reg <= borrow_in;
            idx        <= '0;
            z_acc      <= 1'b1;
          end
        end
        RUN: begin
          dif_acc    <= dif_next;
          borrow_reg <= bout;
          z_acc      <= z_acc & (s == '0);
          if (last_slice) begin
            dif_r     <= dif_next;
            flags_r.n <= s[N-1];
            flags_r.z <= z_acc & (s == '0);
            flags_r.c <= ~bout;
            flags_r.v <= calc_v(a_r[W-1], b_r[W-1], s[N-1]);
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign start_ready = (state == IDLE);
  assign res_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign dif         = dif_r;
  assign flag_n      = flags_r.n;
  assign flag_z      = flags_r.z;
  assign flag_c      = flags_r.c;
  assign flag_v      = flags_r.v;

endmodule

// File: tb/tb_restador_secuencial.sv
// Self-checking bench for restador_secuencial (W=16, N=4): vector table, random ops
// against a single-shot model, backpressure and mid-operation reset sequences.
module tb_restador_secuencial;

  localparam int W = 16;
  localparam int N = 4;
  localparam int K = W / N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid, start_ready;
  logic [W-1:0] a, b;
  logic         borrow_in;
  logic         res_valid, res_ready;
  logic [W-1:0] dif;
  logic         flag_n, flag_z, flag_c, flag_v, busy;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] dif;
    logic [3:0]   nzcv;
  } vec_t;

  typedef struct {
    logic [W-1:0] dif;
    logic [3:0]   nzcv;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[10];

  restador_secuencial #(.N(N), .W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .borrow_in   (borrow_in),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .dif         (dif),
    .flag_n      (flag_n),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .flag_v      (flag_v),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
    logic [W:0] full;
    exp_t e;
    full   = {1'b0, ma} - {1'b0, mb} - (W+1)'(mbin);
    e.dif  = full[W-1:0];
    e.nzcv = {full[W-1], (full[W-1:0] == '0), ~full[W],
              (ma[W-1] ^ mb[W-1]) & (ma[W-1] ^ full[W-1])};
    return e;
  endfunction

  // Drive operands at a falling edge, push the expectation, return after the accept edge.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                          input exp_t e);
    @(negedge clk);
    check("start_ready_before_accept", 32'(start_ready), 32'd1);
    a = ta; b = tb_; borrow_in = tbin; start_valid = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    // Scramble the inputs: the latched operands must not follow them.
    a = ~ta; b = ~tb_; borrow_in = ~tbin;
  endtask

  // Wait (bounded) for res_valid, check latency, pop the scoreboard and compare.
  task automatic wait_result(input string tag);
    int   lat;
    exp_t e;
    lat = 0;
    while (res_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(K));
    if (sb_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_dif"},  32'(dif), 32'(e.dif));
      check({tag, "_nzcv"}, 32'({flag_n, flag_z, flag_c, flag_v}), 32'(e.nzcv));
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tbin, input exp_t e);
    start_op(ta, tb_, tbin, e);
    wait_result(tag);
    @(posedge clk);
    #1;
    check({tag, "_back_to_idle"}, 32'({res_valid, start_ready, busy}), 32'b010);
  endtask

  initial begin
    exp_t  e, held;
    string tag;

    vecs[0] = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 4'b0110};
    vecs[1] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 4'b0010};
    vecs[2] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 4'b1000};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 4'b0011};
    vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 4'b1001};
    vecs[5] = '{16'h0001, 16'h0000, 1'b1, 16'h0000, 4'b0110};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 4'b1000};
    vecs[7] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 4'b0010};
    vecs[8] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 4'b1010};
    vecs[9] = '{16'h8000, 16'h8000, 1'b1, 16'hFFFF, 4'b1000};

    rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b1;
    a = '0; b = '0; borrow_in = 1'b0;
    #1;
    check("reset_outputs", 32'({dif, flag_n, flag_z, flag_c, flag_v}), 32'd0);
    check("reset_handshake", 32'({res_valid, start_ready, busy}), 32'b010);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      e.dif = vecs[i].dif; e.nzcv = vecs[i].nzcv;
      tag = $sformatf("vec%0d", i);
      run_op(tag, vecs[i].a, vecs[i].b, vecs[i].bin, e);
    end

    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] ra, rb;
      logic         rbin;
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      tag = $sformatf("rnd%0d", i);
      run_op(tag, ra, rb, rbin, model(ra, rb, rbin));
    end

    // Backpressure: result held, no new operation accepted while DONE.
    res_ready = 1'b0;
    held = model(16'h4321, 16'h1111, 1'b0);
    start_op(16'h4321, 16'h1111, 1'b0, held);
    wait_result("bp");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      start_valid = c[0]; a = 16'h0F0F; b = 16'h0001;
      check("bp_hold_valid", 32'({res_valid, start_ready, busy}), 32'b101);
      check("bp_hold_dif", 32'(dif), 32'(held.dif));
      check("bp_hold_flags", 32'({flag_n, flag_z, flag_c, flag_v}), 32'(held.nzcv));
    end
    @(negedge clk);
    start_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_idle", 32'({res_valid, start_ready, busy}), 32'b010);
    repeat (2) @(posedge clk);
    #1;
    check("bp_no_queued_op", 32'({res_valid, busy}), 32'b00);
    check("bp_dif_kept", 32'(dif), 32'(held.dif));

    // Asynchronous reset mid-RUN (idx == 2), then a clean operation.
    start_op(16'hFFFF, 16'h0001, 1'b0, model(16'hFFFF, 16'h0001, 1'b0));
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", 32'({dif, flag_n, flag_z, flag_c, flag_v}), 32'd0);
    check("rst_mid_handshake", 32'({res_valid, start_ready, busy}), 32'b010);
    void'(sb_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    e.dif = 16'h0002; e.nzcv = 4'b0010;
    run_op("post_reset", 16'h0005, 16'h0003, 1'b0, e);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/restador_secuencial.md
Name: restador_secuencial

Overview:
Multi-cycle, multi-precision subtraction controller for W-bit operands.
- Reuses one N-bit subtract slice for K = W/N consecutive cycles, least-significant slice first, chaining the borrow between slices.
- Produces the full W-bit difference plus N/Z/C/V flags that match a single-shot W-bit subtractor.
- Sits between the register file/operand source and the flag/result consumers of the lab ALU path. Both sides use valid/ready handshakes.

Parameters:
- N, default 4: slice width in bits.
- W, default 16: operand width. Must be a multiple of N; elaboration error otherwise.
- K (localparam) = W/N: number of slice cycles.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- start_valid, input, 1: operands present.
- start_ready, output, 1: block accepts operands; high only in IDLE.
- a, input, W: minuend. Sampled on accept only.
- b, input, W: subtrahend. Sampled on accept only.
- borrow_in, input, 1: extra borrow; the result is a - b - borrow_in.
- res_valid, output, 1: result and flags valid.
- res_ready, input, 1: consumer takes result.
- dif, output, W: difference.
- flag_n, output, 1: dif[W-1].
- flag_z, output, 1: dif == 0.
- flag_c, output, 1: 1 when no borrow out of the MSB, i.e. unsigned a >= b + borrow_in.
- flag_v, output, 1: signed overflow, (a[W-1]^b[W-1]) & (a[W-1]^dif[W-1]).
- busy, output, 1: state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - dif=0, all flags=0, res_valid=0, busy=0, start_ready=1.
  - Internal slice index, borrow register and operand registers cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - Accept on start_valid & start_ready at a rising edge:
    - latch a and b;
    - borrow_reg = borrow_in;
    - idx = 0; z_acc = 1;
    - go to RUN.
- RUN, one slice per cycle, for idx = 0..K-1:
  - {bout, s} = a_r[idx*N +: N] - b_r[idx*N +: N] - borrow_reg, computed N+1 bits wide.
  - dif_r[idx*N +: N] = s; borrow_reg = bout; z_acc &= (s == 0).
  - On idx == K-1: compute the flags from the final slice, using flag_c = ~bout, then go to DONE. Otherwise idx++.
- DONE:
  - res_valid=1.
  - dif and flags held stable while res_ready=0; no output changes under backpressure.
  - On res_valid & res_ready at an edge: go to IDLE, res_valid=0. dif and flags keep their last values until the next DONE.
- Latency: res_valid rises exactly K cycles after the accept edge (K=4 with defaults). Minimum issue interval is K+2 cycles, because start_ready is low in RUN and DONE.
- a, b and borrow_in changes after accept have no effect.
- start_valid held high in RUN or DONE is ignored, not queued.
- Intermediate dif slices are not exposed: the dif output register updates only on the RUN to DONE transition.
- Reset asserted mid-RUN or in DONE: immediate return to the reset values above, and the operation is discarded.
- K=1 (N==W) is legal: RUN lasts one cycle.
- Borrow wrap: 0 - 1 yields all-ones, flag_c=0.

Decomposition:
- Package restador_pkg:
  - state enum (IDLE, RUN, DONE);
  - packed flags struct {n, z, c, v};
  - function for the overflow expression.
- Sub-module restador_slice #(N): purely combinational N-bit a - b - bin producing {bout, s}. Instantiated once in the controller.

Test Plan (W=16, N=4):
1. a=0x1234, b=0x1234, borrow_in=0, res_ready=1 → dif=0x0000, N=0, Z=1, C=1, V=0. res_valid exactly 4 cycles after accept.
2. a=0x1000, b=0x0001 (borrow ripples through 3 slices) → dif=0x0FFF, C=1, Z=0, N=0, V=0. Then a=0x0000, b=0x0001 → dif=0xFFFF, N=1, C=0, V=0.
3. Signed overflow: a=0x8000, b=0x0001 → dif=0x7FFF, V=1, C=1, N=0. a=0x7FFF, b=0xFFFF → dif=0x8000, V=1, N=1, C=0.
4. borrow_in=1, a=0x0001, b=0x0000 → dif=0x0000, Z=1, C=1.
5. Backpressure: hold res_ready=0 for 5 cycles in DONE → res_valid, dif and flags stable, start_ready=0. start_valid pulsed meanwhile is not accepted. Release res_ready → back to IDLE next cycle.
6. Reset: deassert rst_n asynchronously (mid-cycle) during RUN with idx=2 → all outputs return to reset values immediately. After release, a new operation (0x0005 - 0x0003 → 0x0002) completes correctly.
